// File: rtl/vector_pkg.sv
// Shared types for the vector register-file streamer: raw vector, VRF address,
// per-element write mask and the controller state encoding.
package vector_pkg;

  localparam int unsigned NUM_ELEMS_DEF           = 8;
  localparam int unsigned ELEM_SIZE_DEF           = 16;
  localparam int unsigned ENABLES_PER_ELEMENT_DEF = 4;
  localparam int unsigned VRF_SIZE_DEF            = 32;
  localparam int unsigned AW_DEF = $clog2(VRF_SIZE_DEF);
  localparam int unsigned VW_DEF = NUM_ELEMS_DEF * ELEM_SIZE_DEF;

  typedef logic [VW_DEF-1:0]                    vector_raw_t;
  typedef logic [AW_DEF-1:0]                    vrf_addr_t;
  typedef logic [0:ENABLES_PER_ELEMENT_DEF-1]   elem_mask_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/vector_skid_fifo.sv
// Two-entry valid/ready FIFO that absorbs VRF read data while the read stream stalls.
module vector_skid_fifo
  import vector_pkg::*;
#(
  parameter int unsigned W = VW_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [0:1];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign count     = cnt;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/vector_rf_streamer.sv
// Streams a run of consecutive vector registers out of, or into, the VRF
// over valid/ready streams, one vector per cycle.
module vector_rf_streamer
  import vector_pkg::*;
#(
  parameter int unsigned NUM_ELEMS           = 8,
  parameter int unsigned ELEM_SIZE           = 16,
  parameter int unsigned ENABLES_PER_ELEMENT = 4,
  parameter int unsigned VRF_SIZE            = 32,
  localparam int unsigned AW = $clog2(VRF_SIZE),
  localparam int unsigned VW = NUM_ELEMS * ELEM_SIZE,
  localparam int unsigned MW = NUM_ELEMS * ENABLES_PER_ELEMENT,
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_base,
  input  logic [CW-1:0] cmd_count,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [VW-1:0] rd_data,
  output logic          rd_last,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [VW-1:0] wr_data,
  input  logic [MW-1:0] wr_mask,
  output logic          vrf_en,
  output logic          vrf_we,
  output logic [AW-1:0] vrf_addr,
  output logic [0:ENABLES_PER_ELEMENT-1] vrf_write_mask [0:NUM_ELEMS-1],
  output logic [VW-1:0] vrf_data_w,
  input  logic [VW-1:0] vrf_data_r,
  output logic          done
);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_inc;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] pop_cnt;
  logic [CW-1:0] cnt_clamp;
  logic          inflight;
  logic          push_ok;
  logic          rd_issue;
  logic          rd_pop;
  logic          drain_empty;
  logic          fifo_in_ready;
  logic [1:0]    fifo_cnt;
  logic [2:0]    credit;

  assign cnt_clamp = (cmd_count > CW'(VRF_SIZE)) ? CW'(VRF_SIZE) : cmd_count;
  assign addr_inc  = (addr == AW'(VRF_SIZE - 1)) ? '0 : addr + AW'(1);
  assign rd_pop    = rd_valid & rd_ready;
  assign credit    = 3'(fifo_cnt) + 3'(inflight);
  // Done may follow the final pop directly: the FIFO empties at this edge.
  assign drain_empty = ~inflight & ((fifo_cnt == 2'd0) | ((fifo_cnt == 2'd1) & rd_pop));
  assign rd_last   = rd_valid & (pop_cnt == CW'(1));
  assign vrf_addr  = addr;
  assign push_ok   = inflight & fifo_in_ready;

  vector_skid_fifo #(.W(VW)) u_skid_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (push_ok),
    .in_ready  (fifo_in_ready),
    .in_data   (vrf_data_r),
    .out_valid (rd_valid),
    .out_ready (rd_ready),
    .out_data  (rd_data),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (cmd_valid) state_nx = (cnt_clamp == '0) ? ST_DONE :
                                          (cmd_write ? ST_WRITE : ST_READ);
      ST_READ:  if (rd_issue && (issue_cnt == CW'(1))) state_nx = ST_DRAIN;
      ST_DRAIN: if (drain_empty) state_nx = ST_DONE;
      ST_WRITE: if (wr_valid && (issue_cnt == CW'(1))) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Reads issue only while the FIFO, counting this cycle's pop, can hold the return.
  always_comb begin
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    vrf_en     = 1'b0;
    vrf_we     = 1'b0;
    vrf_data_w = '0;
    done       = 1'b0;
    rd_issue   = 1'b0;
    for (int i = 0; i < NUM_ELEMS; i++) vrf_write_mask[i] = '0;
    unique case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_READ: begin
        rd_issue = (issue_cnt != '0) && (credit < (3'd2 + 3'(rd_pop)));
        vrf_en   = rd_issue;
      end
      ST_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          vrf_en     = 1'b1;
          vrf_we     = 1'b1;
          vrf_data_w = wr_data;
          for (int i = 0; i < NUM_ELEMS; i++)
            for (int j = 0; j < ENABLES_PER_ELEMENT; j++)
              vrf_write_mask[i][j] = wr_mask[i*ENABLES_PER_ELEMENT + j];
        end
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= rd_issue;
      if (cmd_valid && cmd_ready) begin
        addr      <= cmd_base;
        issue_cnt <= cnt_clamp;
        pop_cnt   <= cnt_clamp;
      end else if (vrf_en) begin
        addr      <= addr_inc;
        issue_cnt <= issue_cnt - CW'(1);
      end
      if (rd_pop) pop_cnt <= pop_cnt - CW'(1);
    end
  end

endmodule
